vga_timing_display_out: RTL and testbench

// - Display-side end of the x/y -> rgb drawing interface: generates VGA raster timing and presents the

---
 rtl/vga_timing_display_out.sv | 168 ++++++++++++++++
 tb/tb_vga_timing_display_out.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_display_out.sv
// rtl/vga_timing_display_out.sv - VGA raster timing, x/y presentation and registered, blanked colour/sync output
// Optional feature: define VGA_TEST_PATTERN_EN to let test_mode replace the colour with 8 vertical bars.
`timescale 1ns/1ps

module vga_timing_display_out #(
  parameter int   clk_mhz       = 50,
  parameter int   pixel_mhz     = 25,
  parameter int   screen_width  = 640,
  parameter int   screen_height = 480,
  parameter int   h_front       = 16,
  parameter int   h_sync        = 96,
  parameter int   h_back        = 48,
  parameter int   v_front       = 10,
  parameter int   v_sync        = 2,
  parameter int   v_back        = 33,
  parameter logic hs_pol        = 1'b0,
  parameter logic vs_pol        = 1'b0,
  parameter int   w_red         = 4,
  parameter int   w_green       = 4,
  parameter int   w_blue        = 4,
  parameter int   w_x           = $clog2(screen_width),
  parameter int   w_y           = $clog2(screen_height)
) (
  input  logic               clk,
  input  logic               rst,
  output logic [w_x-1:0]     x,
  output logic [w_y-1:0]     y,
  output logic               display_on,
  input  logic [w_red-1:0]   red,
  input  logic [w_green-1:0] green,
  input  logic [w_blue-1:0]  blue,
  input  logic               test_mode,
  output logic [w_red-1:0]   vga_r,
  output logic [w_green-1:0] vga_g,
  output logic [w_blue-1:0]  vga_b,
  output logic               vga_hs,
  output logic               vga_vs,
  output logic               frame_start
);

  localparam int div_n   = clk_mhz / pixel_mhz;
  localparam int h_total = screen_width + h_front + h_sync + h_back;
  localparam int v_total = screen_height + v_front + v_sync + v_back;
  localparam int w_h     = $clog2(h_total);
  localparam int w_v     = $clog2(v_total);
  localparam int w_div   = (div_n > 1) ? $clog2(div_n) : 1;

  localparam logic [w_h-1:0] h_last     = w_h'(h_total - 1);
  localparam logic [w_v-1:0] v_last     = w_v'(v_total - 1);
  localparam logic [w_h-1:0] h_active   = w_h'(screen_width);
  localparam logic [w_v-1:0] v_active   = w_v'(screen_height);
  localparam logic [w_h-1:0] hs_first   = w_h'(screen_width + h_front);
  localparam logic [w_h-1:0] hs_final   = w_h'(screen_width + h_front + h_sync - 1);
  localparam logic [w_v-1:0] vs_first   = w_v'(screen_height + v_front);
  localparam logic [w_v-1:0] vs_final   = w_v'(screen_height + v_front + v_sync - 1);

  logic           pix_en;
  logic [w_h-1:0] h_cnt;
  logic [w_v-1:0] v_cnt;
  logic           hs_active;
  logic           vs_active;

  logic [w_red-1:0]   pix_r;
  logic [w_green-1:0] pix_g;
  logic [w_blue-1:0]  pix_b;

  // Pixel-rate enable: one clk in every div_n, or every clk when the rates match.
  generate
    if (div_n > 1) begin : g_div
      logic [w_div-1:0] div;

      // Divider counts 0..div_n-1 and restarts on the enable cycle.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          div <= '0;
        end else if (pix_en) begin
          div <= '0;
        end else begin
          div <= div + 1'b1;
        end
      end

      assign pix_en = (div == w_div'(div_n - 1));
    end else begin : g_nodiv
      assign pix_en = 1'b1;
    end
  endgenerate

  // Raster position: h wraps at the end of each line, v advances on each h wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_cnt == h_last) begin
        h_cnt <= '0;
        if (v_cnt == v_last) begin
          v_cnt <= '0;
        end else begin
          v_cnt <= v_cnt + 1'b1;
        end
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  assign display_on = (h_cnt < h_active) && (v_cnt < v_active);
  assign x          = display_on ? h_cnt[w_x-1:0] : '0;
  assign y          = display_on ? v_cnt[w_y-1:0] : '0;
  assign hs_active  = (h_cnt >= hs_first) && (h_cnt <= hs_final);
  assign vs_active  = (v_cnt >= vs_first) && (v_cnt <= vs_final);

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [w_x-1:0] bar_width = w_x'(screen_width / 8);
  logic [w_x-1:0] bar_index;
  assign bar_index = x / bar_width;

  // Colour source: bars replace the drawing logic while test_mode is high.
  always_comb begin
    pix_r = red;
    pix_g = green;
    pix_b = blue;
    if (test_mode) begin
      pix_r = {w_red{bar_index[2]}};
      pix_g = {w_green{bar_index[1]}};
      pix_b = {w_blue{bar_index[0]}};
    end
  end
`else
  logic unused_test_mode;
  assign unused_test_mode = test_mode;

  // Colour source: drawing logic always passes through.
  always_comb begin
    pix_r = red;
    pix_g = green;
    pix_b = blue;
  end
`endif

  // Output stage: colour and sync sampled together so they stay aligned at the pins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
      vga_hs <= ~hs_pol;
      vga_vs <= ~vs_pol;
    end else if (pix_en) begin
      vga_r  <= display_on ? pix_r : '0;
      vga_g  <= display_on ? pix_g : '0;
      vga_b  <= display_on ? pix_b : '0;
      vga_hs <= hs_active ? hs_pol : ~hs_pol;
      vga_vs <= vs_active ? vs_pol : ~vs_pol;
    end
  end

  // Frame pulse: one clk after the tick that leaves the last position of the frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en && (h_cnt == h_last) && (v_cnt == v_last);
    end
  end

endmodule

// File: tb/tb_vga_timing_display_out.sv
// tb/tb_vga_timing_display_out.sv - scoreboard bench for vga_timing_display_out on a reduced raster
`timescale 1ns/1ps

module tb_vga_timing_display_out;

  localparam int SW    = 16;
  localparam int SH    = 8;
  localparam int HF    = 2;
  localparam int HS    = 3;
  localparam int HB    = 3;
  localparam int VF    = 1;
  localparam int VS    = 2;
  localparam int VB    = 2;
  localparam int HT    = SW + HF + HS + HB;
  localparam int VT    = SH + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int NDIV  = 2;
`ifdef VGA_TEST_PATTERN_EN
  localparam bit PAT = 1'b1;
`else
  localparam bit PAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] x;
  logic [2:0] y;
  logic       display_on;
  logic [3:0] red, green, blue;
  logic       test_mode;
  logic [3:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, frame_start;

  typedef struct {
    int r, g, b, hs, vs, fs, x, y, don;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   run = 1'b0;

  always #5 clk = ~clk;

  // Drawing logic under test: combinational from the presented coordinate.
  assign red   = x ^ {1'b0, y};
  assign green = ~x;
  assign blue  = {1'b1, y};

  vga_timing_display_out #(
    .clk_mhz(50), .pixel_mhz(25),
    .screen_width(SW), .screen_height(SH),
    .h_front(HF), .h_sync(HS), .h_back(HB),
    .v_front(VF), .v_sync(VS), .v_back(VB),
    .hs_pol(1'b0), .vs_pol(1'b0),
    .w_red(4), .w_green(4), .w_blue(4)
  ) dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .display_on(display_on),
    .red(red), .green(green), .blue(blue), .test_mode(test_mode),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .frame_start(frame_start)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_vga_r"}, int'(vga_r), 0);
    chk({tag, "_vga_g"}, int'(vga_g), 0);
    chk({tag, "_vga_b"}, int'(vga_b), 0);
    chk({tag, "_vga_hs"}, int'(vga_hs), 1);
    chk({tag, "_vga_vs"}, int'(vga_vs), 1);
    chk({tag, "_x"}, int'(x), 0);
    chk({tag, "_y"}, int'(y), 0);
    chk({tag, "_display_on"}, int'(display_on), 1);
    chk({tag, "_frame_start"}, int'(frame_start), 0);
  endtask

  // Expectation generator: predicts each clk's outputs from clocks since release.
  initial begin
    int p, q, qh, qv, pos, ph, pv, bi;
    int m_r, m_g, m_b, m_hs, m_vs, m_fs;
    exp_t e;
    p = 0; m_r = 0; m_g = 0; m_b = 0; m_hs = 1; m_vs = 1; m_fs = 0;
    forever begin
      @(posedge clk);
      if (!run) begin
        p = 0; m_r = 0; m_g = 0; m_b = 0; m_hs = 1; m_vs = 1; m_fs = 0;
      end else begin
        p++;
        m_fs = 0;
        if (p % NDIV == 0) begin
          q  = (p / NDIV - 1) % FRAME;
          qh = q % HT;
          qv = q / HT;
          if (qh < SW && qv < SH) begin
            if (PAT && test_mode) begin
              bi  = qh / (SW / 8);
              m_r = bi[2] ? 15 : 0;
              m_g = bi[1] ? 15 : 0;
              m_b = bi[0] ? 15 : 0;
            end else begin
              m_r = (qh ^ qv) & 15;
              m_g = (~qh) & 15;
              m_b = 8 | qv;
            end
          end else begin
            m_r = 0; m_g = 0; m_b = 0;
          end
          m_hs = (qh >= SW + HF && qh <= SW + HF + HS - 1) ? 0 : 1;
          m_vs = (qv >= SH + VF && qv <= SH + VF + VS - 1) ? 0 : 1;
          m_fs = (q == FRAME - 1) ? 1 : 0;
        end
        pos = (p / NDIV) % FRAME;
        ph  = pos % HT;
        pv  = pos / HT;
        e.r = m_r; e.g = m_g; e.b = m_b; e.hs = m_hs; e.vs = m_vs; e.fs = m_fs;
        e.don = (ph < SW && pv < SH) ? 1 : 0;
        e.x   = e.don ? ph : 0;
        e.y   = e.don ? pv : 0;
        sb.push_back(e);
      end
    end
  end

  // Monitor: compares DUT outputs on the falling edge against queued expectations.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("vga_r", int'(vga_r), e.r);
        chk("vga_g", int'(vga_g), e.g);
        chk("vga_b", int'(vga_b), e.b);
        chk("vga_hs", int'(vga_hs), e.hs);
        chk("vga_vs", int'(vga_vs), e.vs);
        chk("frame_start", int'(frame_start), e.fs);
        chk("x", int'(x), e.x);
        chk("y", int'(y), e.y);
        chk("display_on", int'(display_on), e.don);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  found;
    rst = 1'b0;
    test_mode = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("reset");

    @(negedge clk);
    rst = 1'b1;
    run = 1'b1;

    // First frame with pass-through colour, second with test_mode requested.
    repeat (FRAME * NDIV + 6) @(negedge clk);
    test_mode = 1'b1;
    repeat (FRAME * NDIV) @(negedge clk);
    test_mode = 1'b0;

    // Abort mid-frame around line 5 and confirm the reset takes effect at once.
    repeat (250) @(posedge clk);
    #3;
    run = 1'b0;
    sb.delete();
    rst = 1'b0;
    #1;
    chk_reset("midreset");
    repeat (3) @(negedge clk);
    chk_reset("midreset_hold");

    @(negedge clk);
    rst = 1'b1;
    run = 1'b1;
    n = 0;
    found = 1'b0;
    for (int i = 0; i < 3 * FRAME * NDIV && !found; i++) begin
      @(posedge clk);
      n++;
      #1;
      if (frame_start) found = 1'b1;
    end
    chk("restart_frame_start_clks", found ? n : -1, FRAME * NDIV);

    repeat (40) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
